// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared register-file widths and write-back requester indices
package cpu_pkg;
  localparam int REG_AW = 5;
  localparam int REG_DW = 32;
  localparam int NREGS  = 32;
  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

  localparam int WB_ALU  = 0;
  localparam int WB_MEM  = 1;
  localparam int WB_MDU  = 2;
  localparam int WB_NREQ = 3;
endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin picker starting at ptr
module rr_arbiter #(
  parameter int NREQ = 3
) (
  input  logic [NREQ-1:0] req,
  input  logic [2:0]      ptr,
  input  logic            enable,
  output logic [NREQ-1:0] grant,
  output logic [2:0]      index
);
  int   j;
  logic found;

  always_comb begin
    grant = '0;
    index = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(ptr) + k) % NREQ;
      if (enable && !found && req[j]) begin
        grant[j] = 1'b1;
        index    = 3'(j);
        found    = 1'b1;
      end
    end
  end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - round-robin sharing of the register file write port plus busy scoreboard
module regfile_wb_arbiter
  import cpu_pkg::*;
#(
  parameter int NREQ = WB_NREQ,
  parameter int DW   = REG_DW,
  parameter int AW   = REG_AW
) (
  input  logic               clock,
  input  logic               rst_n,
  input  logic               wb_stall,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*AW-1:0] req_reg_no,
  input  logic [NREQ*DW-1:0] req_data,
  output logic               wr,
  output logic [AW-1:0]      wr_register_no,
  output logic [DW-1:0]      wr_data,
  output logic [2:0]         grant_id,
  input  logic               sb_set,
  input  logic [AW-1:0]      sb_set_no,
  output logic [NREGS-1:0]   busy_vec
);
  logic [NREQ-1:0]  grant;
  logic [2:0]       gnt_idx;
  logic             xfer;
  logic [AW-1:0]    sel_reg;
  logic [DW-1:0]    sel_data;

  logic [2:0]       ptr_q, ptr_d;
  logic             wr_q, wr_d;
  logic [AW-1:0]    wr_register_no_q, wr_register_no_d;
  logic [DW-1:0]    wr_data_q, wr_data_d;
  logic [2:0]       grant_id_q, grant_id_d;
  logic [NREGS-1:0] busy_q, busy_d;

  // Reset also gates the enable so req_ready reads 0 while rst_n is low.
  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req    (req_valid),
    .ptr    (ptr_q),
    .enable (~wb_stall & rst_n),
    .grant  (grant),
    .index  (gnt_idx)
  );

  assign req_ready = grant;
  assign xfer      = |grant;
  assign sel_reg   = req_reg_no[int'(gnt_idx)*AW +: AW];
  assign sel_data  = req_data[int'(gnt_idx)*DW +: DW];

  always_comb begin
    ptr_d            = ptr_q;
    wr_d             = 1'b0;
    wr_register_no_d = wr_register_no_q;
    wr_data_d        = wr_data_q;
    grant_id_d       = grant_id_q;
    if (xfer) begin
      // r0 writes are accepted and rotate the pointer, but never reach the file.
      wr_d             = (sel_reg != AW'(REG_ZERO));
      wr_register_no_d = sel_reg;
      wr_data_d        = sel_data;
      grant_id_d       = gnt_idx;
      ptr_d            = (int'(gnt_idx) == NREQ-1) ? 3'd0 : gnt_idx + 3'd1;
    end
  end

  // Set is applied after clear so a fresh producer of the same register wins.
  always_comb begin
    busy_d = busy_q;
    if (wr_q) busy_d[wr_register_no_q] = 1'b0;
    if (sb_set && sb_set_no != AW'(REG_ZERO)) busy_d[sb_set_no] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q            <= '0;
      wr_q             <= 1'b0;
      wr_register_no_q <= '0;
      wr_data_q        <= '0;
      grant_id_q       <= '0;
      busy_q           <= '0;
    end else begin
      ptr_q            <= ptr_d;
      wr_q             <= wr_d;
      wr_register_no_q <= wr_register_no_d;
      wr_data_q        <= wr_data_d;
      grant_id_q       <= grant_id_d;
      busy_q           <= busy_d;
    end
  end

  assign wr             = wr_q;
  assign wr_register_no = wr_register_no_q;
  assign wr_data        = wr_data_q;
  assign grant_id       = grant_id_q;
  assign busy_vec       = busy_q;
endmodule
